// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared states and constants for the instruction-memory loader
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_WRITE,
        ST_CHECK,
        ST_DONE,
        ST_ERR
    } state_t;

    localparam int         BYTES_PER_WORD = 4;
    localparam logic [7:0] PAD_BYTE       = 8'h00;

endpackage

// File: rtl/imem_word_packer.sv
// rtl/imem_word_packer.sv - big-endian byte-to-word packer with zero padding of a short final word
module imem_word_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic        last,
    input  logic [7:0]  data,
    output logic [31:0] word,
    output logic        word_full
);

    logic [31:0] wbuf;
    logic [1:0]  byte_cnt;

    // word is the packed value including the byte being pushed this cycle
    always_comb begin
        word = {wbuf[23:0], data};
        if (last) begin
            case (byte_cnt)
                2'd0:    word = {data, PAD_BYTE, PAD_BYTE, PAD_BYTE};
                2'd1:    word = {wbuf[7:0], data, PAD_BYTE, PAD_BYTE};
                2'd2:    word = {wbuf[15:0], data, PAD_BYTE};
                default: word = {wbuf[23:0], data};
            endcase
        end
        word_full = push && (last || byte_cnt == 2'(BYTES_PER_WORD - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wbuf     <= '0;
            byte_cnt <= '0;
        end else if (push) begin
            wbuf     <= word;
            byte_cnt <= word_full ? 2'd0 : byte_cnt + 2'd1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream loader for MIPS instruction memory, holds the core in reset until loaded
// Optional trailing XOR checksum byte: IMEM_LOADER_CHECKSUM_EN
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64,
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_data,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              err
);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] word_addr;
    logic              last_flag;
    logic              xfer;
    logic              push;
    logic [31:0]       word;
    logic              word_full;

    assign xfer = in_valid && in_ready;
    assign push = xfer && (state == ST_LOAD);

    imem_word_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .last      (in_last),
        .data      (in_data),
        .word      (word),
        .word_full (word_full)
    );

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] csum;

    always_ff @(posedge clk) begin
        if (rst)
            csum <= '0;
        else if (push)
            csum <= csum ^ in_data;
    end
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            ST_LOAD: begin
                if (word_full)
                    state_nxt = ST_WRITE;
            end
            ST_WRITE: begin
                // a terminated program wins over a full memory on the final address
                if (last_flag)
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_nxt = ST_CHECK;
`else
                    state_nxt = ST_DONE;
`endif
                else if (word_addr == ADDR_W'(DEPTH - 1))
                    state_nxt = ST_ERR;
                else
                    state_nxt = ST_LOAD;
            end
            ST_CHECK: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (xfer)
                    state_nxt = (in_data == csum) ? ST_DONE : ST_ERR;
`else
                state_nxt = ST_ERR;
`endif
            end
            default: state_nxt = state;
        endcase
    end

    // outputs are registered from the next state so they line up with it
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_LOAD;
            word_addr  <= '0;
            last_flag  <= 1'b0;
            in_ready   <= 1'b1;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_rst    <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state <= state_nxt;
            if (word_full) begin
                last_flag  <= in_last;
                imem_addr  <= word_addr;
                imem_wdata <= WORD_W'(word);
            end
            if (state == ST_WRITE)
                word_addr <= word_addr + 1'b1;
            in_ready <= (state_nxt == ST_LOAD) || (state_nxt == ST_CHECK);
            imem_we  <= (state_nxt == ST_WRITE);
            cpu_rst  <= (state_nxt != ST_DONE);
            done     <= (state_nxt == ST_DONE);
            err      <= (state_nxt == ST_ERR);
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed bench for imem_loader (checksum cases under IMEM_LOADER_CHECKSUM_EN)
module tb_imem_loader;

    localparam int ADDR_W = 6;
    localparam int DEPTH  = 64;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [7:0]        in_data = 8'h00;
    logic              in_last = 1'b0;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_rst;
    logic              done;
    logic              err;

    int nvec = 0;
    int nerr = 0;
    logic [ADDR_W+31:0] wq[$];

    imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .WORD_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_rst    (cpu_rst),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, v, l;
        logic [7:0]  d;
        logic        rdy, we, cpu, dn, er, chk;
        logic [5:0]  addr;
        logic [31:0] wd;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // capture every write strobe; the stream must be stalled while writing
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wq.push_back({imem_addr, imem_wdata});
            chk("ready_low_on_write", 64'(in_ready), 64'd0);
        end
    end

    function automatic void add(input logic r, v, l, input logic [7:0] d,
                                input logic rdy, we, cpu, dn, er, ck,
                                input logic [5:0] a, input logic [31:0] wd);
        vec_t t;
        t.rst = r; t.v = v; t.l = l; t.d = d;
        t.rdy = rdy; t.we = we; t.cpu = cpu; t.dn = dn; t.er = er; t.chk = ck;
        t.addr = a; t.wd = wd;
        tbl.push_back(t);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        wq.delete();
    endtask

    task automatic send(input logic [7:0] b[$], input bit use_last, input bit toggle, input logic [8:0] extra);
        logic [7:0] q[$];
        int i = 0;
        int cyc = 0;
        q = b;
        if (extra[8])
            q.push_back(extra[7:0]);
        while (i < q.size() && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (toggle && (cyc % 2 == 0)) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_data  = q[i];
                in_last  = use_last && (i == b.size() - 1);
                if (in_ready)
                    i++;
            end
        end
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        chk("send_bytes_consumed", 64'(i), 64'(q.size()));
    endtask

    task automatic check_writes(input string nm, input logic [ADDR_W+31:0] exp[$]);
        chk({nm, "_count"}, 64'(wq.size()), 64'(exp.size()));
        foreach (exp[k])
            if (k < wq.size())
                chk({nm, "_word"}, 64'(wq[k]), 64'(exp[k]));
    endtask

    task automatic check_status(input string nm, input logic dn, input logic er, input logic cpu);
        chk({nm, "_done"}, 64'(done), 64'(dn));
        chk({nm, "_err"}, 64'(err), 64'(er));
        chk({nm, "_cpu_rst"}, 64'(cpu_rst), 64'(cpu));
        chk({nm, "_ready"}, 64'(in_ready), 64'd0);
    endtask

    initial begin
        logic [ADDR_W+31:0] exp[$];
        logic [7:0]         bytes[$];

        // rst v l data   rdy we cpu dn er chk addr wdata
        add(1, 0, 0, 8'h00, 1, 0, 1, 0, 0, 1, 6'd0, 32'h0);
        add(0, 1, 0, 8'h20, 1, 0, 1, 0, 0, 0, 6'd0, 32'h0);
        add(0, 1, 0, 8'h08, 1, 0, 1, 0, 0, 0, 6'd0, 32'h0);
        add(0, 1, 0, 8'h00, 1, 0, 1, 0, 0, 0, 6'd0, 32'h0);
        add(0, 1, 0, 8'h05, 0, 1, 1, 0, 0, 1, 6'd0, 32'h20080005);
        add(0, 1, 0, 8'h00, 1, 0, 1, 0, 0, 0, 6'd0, 32'h0);
        add(0, 1, 0, 8'h00, 1, 0, 1, 0, 0, 0, 6'd0, 32'h0);
        add(0, 1, 0, 8'h00, 1, 0, 1, 0, 0, 0, 6'd0, 32'h0);
        add(0, 1, 0, 8'h00, 1, 0, 1, 0, 0, 0, 6'd0, 32'h0);
        add(0, 1, 1, 8'h00, 0, 1, 1, 0, 0, 1, 6'd1, 32'h0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        add(0, 0, 0, 8'h00, 1, 0, 1, 0, 0, 0, 6'd0, 32'h0);
        add(0, 1, 0, 8'h2D, 0, 0, 0, 1, 0, 0, 6'd0, 32'h0);
`else
        add(0, 0, 0, 8'h00, 0, 0, 0, 1, 0, 0, 6'd0, 32'h0);
`endif
        add(0, 1, 0, 8'hFF, 0, 0, 0, 1, 0, 0, 6'd0, 32'h0);

        foreach (tbl[k]) begin
            @(negedge clk);
            rst = tbl[k].rst; in_valid = tbl[k].v; in_data = tbl[k].d; in_last = tbl[k].l;
            @(posedge clk);
            #1;
            chk($sformatf("t1_ready_%0d", k), 64'(in_ready), 64'(tbl[k].rdy));
            chk($sformatf("t1_we_%0d", k), 64'(imem_we), 64'(tbl[k].we));
            chk($sformatf("t1_cpu_rst_%0d", k), 64'(cpu_rst), 64'(tbl[k].cpu));
            chk($sformatf("t1_done_%0d", k), 64'(done), 64'(tbl[k].dn));
            chk($sformatf("t1_err_%0d", k), 64'(err), 64'(tbl[k].er));
            if (tbl[k].chk) begin
                chk($sformatf("t1_addr_%0d", k), 64'(imem_addr), 64'(tbl[k].addr));
                chk($sformatf("t1_wdata_%0d", k), 64'(imem_wdata), 64'(tbl[k].wd));
            end
        end
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;

        // short final word is zero padded
        do_reset();
        send('{8'h8C, 8'h01, 8'h00, 8'h04, 8'hAA, 8'hBB}, 1'b1, 1'b0, {CK, 8'h98});
        repeat (6) @(negedge clk);
        exp = '{{6'd0, 32'h8C010004}, {6'd1, 32'hAABB0000}};
        check_writes("t2", exp);
        check_status("t2", 1'b1, 1'b0, 1'b0);

        // throttled source gives identical writes
        do_reset();
        send('{8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b1, 1'b1, {CK, 8'h2D});
        repeat (6) @(negedge clk);
        exp = '{{6'd0, 32'h20080005}, {6'd1, 32'h00000000}};
        check_writes("t3", exp);
        check_status("t3", 1'b1, 1'b0, 1'b0);

        // unterminated program fills memory and errors out
        do_reset();
        bytes.delete();
        exp.delete();
        for (int n = 0; n < 4 * DEPTH; n++)
            bytes.push_back(8'(n));
        for (int w = 0; w < DEPTH; w++)
            exp.push_back({6'(w), 8'(4 * w), 8'(4 * w + 1), 8'(4 * w + 2), 8'(4 * w + 3)});
        send(bytes, 1'b0, 1'b0, 9'h000);
        repeat (6) @(negedge clk);
        check_writes("t4", exp);
        check_status("t4", 1'b0, 1'b1, 1'b1);

        // reset mid-word, with a byte offered in the reset cycle
        do_reset();
        send('{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5}, 1'b0, 1'b0, 9'h000);
        chk("t5_first_word_written", 64'(wq.size()), 64'd1);
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; in_data = 8'h99; in_last = 1'b1;
        @(posedge clk);
        #1;
        chk("t5_rst_ready", 64'(in_ready), 64'd1);
        chk("t5_rst_cpu_rst", 64'(cpu_rst), 64'd1);
        chk("t5_rst_we", 64'(imem_we), 64'd0);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        wq.delete();
        send('{8'h11, 8'h22, 8'h33, 8'h44}, 1'b1, 1'b0, {CK, 8'h44});
        repeat (6) @(negedge clk);
        exp = '{{6'd0, 32'h11223344}};
        check_writes("t5", exp);
        check_status("t5", 1'b1, 1'b0, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        do_reset();
        send('{8'h01, 8'h02, 8'h03, 8'h04}, 1'b1, 1'b0, 9'h104);
        repeat (6) @(negedge clk);
        exp = '{{6'd0, 32'h01020304}};
        check_writes("t6_good", exp);
        check_status("t6_good", 1'b1, 1'b0, 1'b0);

        do_reset();
        send('{8'h01, 8'h02, 8'h03, 8'h04}, 1'b1, 1'b0, 9'h105);
        repeat (6) @(negedge clk);
        check_writes("t6_bad", exp);
        check_status("t6_bad", 1'b0, 1'b1, 1'b1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Byte-stream writer for the single-cycle MIPS instruction memory. It is the write side of the memory the CPU fetches from on each PC step.
- Accepts a program as bytes over a valid/ready stream and packs them big-endian into 32-bit words. It writes one word per location and holds the CPU in reset until the load completes.
- Sits between the bench/host byte source and the instruction memory write port. It drives the CPU's reset.

Parameters:
- ADDR_W, 6, word-address width of instruction memory (64 words = 8-bit byte PC).
- DEPTH, 64, number of instruction words; must be less than or equal to 2**ADDR_W.
- WORD_W, 32, instruction width; fixed at 32, four bytes per word.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  byte-stream valid.
- in_ready  output  1  byte-stream ready; a transfer occurs when in_valid and in_ready are both high at the clock edge.
- in_data  input  8  program byte; first byte of each word is its MSB.
- in_last  input  1  marks the final program byte.
- imem_we  output  1  one-cycle instruction-memory write strobe.
- imem_addr  output  ADDR_W  word address of the write.
- imem_wdata  output  32  word to write.
- cpu_rst  output  1  reset to the MIPS core, active-high.
- done  output  1  load complete, sticky until rst.
- err  output  1  overflow or checksum failure, sticky until rst.

Behaviour:
- All outputs are registered.
- Reset values:
  - state=LOAD, byte_cnt=0, word_addr=0, wbuf=0.
  - in_ready=1, imem_we=0, imem_addr=0, imem_wdata=0.
  - cpu_rst=1, done=0, err=0.
- States: LOAD, WRITE, DONE, ERR (CHECK only with the optional feature).
- LOAD:
  - in_ready=1.
  - Each transfer does wbuf <= {wbuf[23:0], in_data} and byte_cnt += 1 (mod 4).
- LOAD -> WRITE:
  - Occurs on the transfer that completes a word (byte_cnt==3), or on any transfer with in_last=1.
  - On in_last with byte_cnt<3, the word is left-aligned and zero-padded. Example: 2 bytes AA,BB give 0xAABB0000.
  - A latched last flag records in_last.
- WRITE (exactly one cycle):
  - in_ready=0, imem_we=1, imem_addr=word_addr, imem_wdata=packed word.
  - imem_we therefore rises in the cycle after the completing handshake.
  - word_addr += 1 and byte_cnt=0.
- Exit from WRITE:
  - last flag set -> DONE.
  - else word_addr==DEPTH-1 -> ERR (memory full, program not terminated).
  - else -> LOAD.
- DONE:
  - cpu_rst=0, done=1, in_ready=0.
  - cpu_rst falls the cycle after the final write strobe.
  - Only rst leaves DONE.
- ERR:
  - cpu_rst=1, err=1, in_ready=0.
  - Only rst leaves ERR.
- in_valid while in_ready=0: no transfer; the byte is not consumed and the source holds it.
- rst mid-load: the partial word is discarded, no write is issued, and the block restarts at address 0 with cpu_rst=1.
- rst asserted in the same cycle as a transfer: the reset wins and the byte is dropped.
- in_last on the word written to address DEPTH-1: goes to DONE, not ERR.
- Words beyond the last written address are not touched.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- With the macro defined:
  - An 8-bit XOR is accumulated over all program bytes.
  - WRITE with the last flag set goes to CHECK instead of DONE; CHECK has in_ready=1.
  - The next transferred byte is compared with the accumulator: equal -> DONE, unequal -> ERR.
  - The checksum byte is never written to memory. Reset clears the accumulator.
- Without the macro: no accumulator and no CHECK state; behaviour is exactly as above.

Decomposition:
- Package imem_loader_pkg holds:
  - the state enum (LOAD, WRITE, CHECK, DONE, ERR);
  - BYTES_PER_WORD=4;
  - the pad byte constant 8'h00.
- Sub-module imem_word_packer holds the shift register, byte counter and zero-pad logic. Its outputs are word and word_full.
- The FSM, address counter and reset control stay in the top level.

Test Plan:
- Stream 8 bytes 20,08,00,05,00,00,00,00 with in_last on byte 8 -> writes [0]=0x20080005 and [1]=0x00000000. done=1 and cpu_rst=0 in the cycle after the second imem_we.
- Stream 6 bytes 8C,01,00,04,AA,BB with in_last on byte 6 -> writes [1]=0xAABB0000. No further writes.
- Source with in_valid toggling every other cycle -> same words and addresses as the back-to-back case. in_ready=0 on every WRITE cycle.
- Stream 256 bytes with no in_last (DEPTH=64) -> 64 writes, then err=1 and cpu_rst stays 1. in_ready=0 afterwards.
- Assert rst after 2 bytes of the second word, then stream 4 bytes 11,22,33,44 with in_last -> [0]=0x11223344, done=1.
- With IMEM_LOADER_CHECKSUM_EN, bytes 01,02,03,04 (last), then 04 -> DONE. Repeating with a checksum byte of 05 -> err=1.
